// File: rtl/lz_mask_decoder_pkg.sv
// Shared types and sizing for the leading-zero mask decoder.
package lz_mask_decoder_pkg;

  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_e;

  localparam int LZ_WIDTH = 32;
  localparam int LZ_GROUP = 8;
  localparam int NG       = LZ_WIDTH / LZ_GROUP;
  localparam int GIW      = (NG > 1) ? $clog2(NG) : 1;

  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lz_mask_group_slice.sv
// Combinational generator for one GROUP-bit slice of the decoded word.
// Optional one-hot mode under LZ_MASK_DECODER_ONEHOT_EN.
module lz_mask_group_slice
  import lz_mask_decoder_pkg::*;
#(
  parameter int WIDTH = LZ_WIDTH,
  parameter int GROUP = LZ_GROUP,
  parameter int CW    = calc_cw(WIDTH),
  parameter int GW    = GIW
) (
  input  logic [GW-1:0]    g,
  input  logic [CW-1:0]    cnt,
`ifdef LZ_MASK_DECODER_ONEHOT_EN
  input  logic             onehot,
`endif
  output logic [GROUP-1:0] grp
);

  // Bit k of the slice is absolute MSB-index g*GROUP+k; slice MSB is k=0.
  always_comb begin
    grp = '0;
    for (int k = 0; k < GROUP; k++) begin
`ifdef LZ_MASK_DECODER_ONEHOT_EN
      if (onehot)
        grp[GROUP-1-k] = ((int'(g) * GROUP + k) == int'(cnt));
      else
        grp[GROUP-1-k] = ((int'(g) * GROUP + k) >= int'(cnt));
`else
      grp[GROUP-1-k] = ((int'(g) * GROUP + k) >= int'(cnt));
`endif
    end
  end

endmodule

// File: rtl/lz_mask_decoder.sv
// Iterative inverse of a leading-zero counter: builds count zeros then ones, one group per cycle.
// Optional one-hot output mode enabled by LZ_MASK_DECODER_ONEHOT_EN.
module lz_mask_decoder
  import lz_mask_decoder_pkg::*;
#(
  parameter int WIDTH = LZ_WIDTH,
  parameter int GROUP = LZ_GROUP,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
`ifdef LZ_MASK_DECODER_ONEHOT_EN
  input  logic             in_onehot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_sat
);

  localparam int NGL = WIDTH / GROUP;
  localparam int GW  = (NGL > 1) ? $clog2(NGL) : 1;

  state_e           state_q, state_d;
  logic [GW-1:0]    g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [GROUP-1:0] grp;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
  logic             onehot_q, onehot_d;
`endif

  lz_mask_group_slice #(
    .WIDTH (WIDTH),
    .GROUP (GROUP),
    .CW    (CW),
    .GW    (GW)
  ) u_slice (
    .g      (g_q),
    .cnt    (cnt_q),
`ifdef LZ_MASK_DECODER_ONEHOT_EN
    .onehot (onehot_q),
`endif
    .grp    (grp)
  );

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    word_d      = word_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
    onehot_d    = onehot_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          cnt_d      = (in_count > CW'(WIDTH)) ? CW'(WIDTH) : in_count;
          sat_d      = (in_count > CW'(WIDTH));
          word_d     = '0;
          g_d        = '0;
          in_ready_d = 1'b0;
          state_d    = BUILD;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
          onehot_d   = in_onehot;
`endif
        end
      end
      BUILD: begin
        // MSB group is produced first, so shifting left lands it at the top after NG steps.
        word_d = {word_q[WIDTH-GROUP-1:0], grp};
        g_d    = g_q + GW'(1);
        if (g_q == GW'(NGL - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      word_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
      onehot_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
      onehot_q    <= onehot_d;
`endif
    end
  end

  // Partial words built during BUILD are never visible outside.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_valid_q ? word_q : '0;
  assign out_sat   = out_valid_q & sat_q;

endmodule

// File: tb/tb_lz_mask_decoder.sv
// Randomized self-checking bench for lz_mask_decoder against a behavioural mask/one-hot model.
module tb_lz_mask_decoder;

  localparam int W  = 32;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_count;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_sat;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
  logic          in_onehot;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lz_mask_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
`ifdef LZ_MASK_DECODER_ONEHOT_EN
    .in_onehot (in_onehot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_sat   (out_sat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: count zeros from the MSB followed by ones, or a single bit at W-1-count.
  function automatic logic [W-1:0] ref_word(input int cnt, input bit oh);
    int c;
    logic [W-1:0] ones;
    logic [W-1:0] top;
    c    = (cnt > W) ? W : cnt;
    ones = '1;
    top  = 32'h8000_0000;
    if (c >= W) return '0;
    return oh ? (top >> c) : (ones >> c);
  endfunction

  function automatic int lzc(input logic [W-1:0] v);
    int n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return n;
      n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; caller is positioned #1 after a rising edge with the decoder idle.
  task automatic run(input int cnt, input int stall, input bit oh, input bit roundtrip);
    int lat;
    logic [W-1:0] exp;
    exp = ref_word(cnt, oh);
    check_eq("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_count  = 6'(cnt);
`ifdef LZ_MASK_DECODER_ONEHOT_EN
    in_onehot = oh;
`endif
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    check_eq("in_ready_build", in_ready, 0);
    check_eq("word_gated", {out_sat, out_word}, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, NG);
    check_eq("word", out_word, exp);
    check_eq("sat", out_sat, (cnt > W));
    if (roundtrip) check_eq("roundtrip", lzc(out_word), cnt);
    for (int s = 0; s < stall; s++) begin
      check_eq("in_ready_done", in_ready, 0);
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_word", out_word, exp);
    end
    out_ready = 1'b1;
    tick();
    check_eq("in_ready_after", in_ready, 1);
    check_eq("valid_after", out_valid, 0);
    check_eq("word_after", out_word, 0);
  endtask

  initial begin
    bit oh;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = '0;
    out_ready = 1'b1;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
    in_onehot = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_word", out_word, 0);
    check_eq("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    tick();

    run(0, 0, 1'b0, 1'b0);
    run(5, 0, 1'b0, 1'b0);
    run(32, 0, 1'b0, 1'b0);
    run(40, 0, 1'b0, 1'b0);
    run(63, 0, 1'b0, 1'b0);
    run(17, 6, 1'b0, 1'b0);

    // Reset during the second BUILD cycle discards the request.
    in_valid = 1'b1;
    in_count = 6'd9;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_word", out_word, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("post_rst_valid", out_valid, 0);
      check_eq("post_rst_sat", out_sat, 0);
    end
    run(1, 0, 1'b0, 1'b0);

`ifdef LZ_MASK_DECODER_ONEHOT_EN
    run(5, 0, 1'b1, 1'b0);
    run(0, 0, 1'b1, 1'b0);
    run(32, 0, 1'b1, 1'b0);
    run(45, 1, 1'b1, 1'b0);
`endif

    for (int c = 0; c <= W; c++) run(c, 0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      oh = 1'b0;
`ifdef LZ_MASK_DECODER_ONEHOT_EN
      oh = 1'($urandom_range(0, 1));
`endif
      run(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), oh, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lz_mask_decoder.md
Name: lz_mask_decoder

Overview:
- Inverse of the 32-bit leading-zero-count encoder used in the arithmetic benchmarks.
- Takes a leading-zero count and produces the 32-bit word whose leading-zero count equals it: `count` zeros from the MSB, then all ones.
- Iterative: builds the word one group of bits per cycle, MSB group first. Valid/ready on both sides.
- Used as the round-trip partner of the encoder in equivalence and regression benches.

Parameters:
- WIDTH, 32: output word width; must be a multiple of GROUP.
- GROUP, 8: bits generated per BUILD cycle; NG = WIDTH/GROUP.
- CW, $clog2(WIDTH+1) = 6: count input width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  count request valid.
- in_ready  out  1  decoder can accept a request.
- in_count  in  CW  requested leading-zero count.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result.
- out_word  out  WIDTH  decoded word.
- out_sat  out  1  in_count exceeded WIDTH and was saturated.

Behaviour:
- Reset (async assert, sync-safe release):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_word=0, out_sat=0.
  - Group index, captured count and shift register are all cleared.
- FSM states: IDLE, BUILD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture cnt = min(in_count, WIDTH), set sat flag = (in_count > WIDTH), clear the word register, set g=0, go to BUILD.
- BUILD (in_ready=0):
  - Each cycle produces group g. Bit k of the group (k=0 is the group MSB) has absolute MSB-index i = g*GROUP + k, and its value is 1 iff i >= cnt.
  - The group is placed at out_word bits [WIDTH-1-g*GROUP -: GROUP]; g increments.
  - After group NG-1 is done, go to DONE.
  - Fixed latency: exactly NG BUILD cycles, with no early exit.
- DONE:
  - out_valid=1; out_word and out_sat are stable.
  - When out_valid&out_ready, go to IDLE the next cycle.
  - in_ready stays 0 in DONE; there is no overlap of consecutive requests.
- Latency:
  - Acceptance edge at cycle T; out_valid is first high in cycle T+NG+1 (T+5 at the defaults).
  - Minimum throughput: one result per NG+2 cycles.
- Output gating: while out_valid=0, out_word=0 and out_sat=0.
- Boundary values:
  - cnt=0 gives all ones.
  - cnt=WIDTH gives all zeros.
  - in_count > WIDTH gives all zeros with out_sat=1.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset mid-BUILD or mid-DONE: immediate return to IDLE; any partial word is discarded and never presented.
- in_valid in BUILD/DONE is ignored; the upstream must hold it until in_ready.
- Round-trip invariant: for cnt <= WIDTH, the leading-zero count of out_word equals cnt.

Optional Feature:
- Macro LZ_MASK_DECODER_ONEHOT_EN.
- When defined:
  - Adds input port `in_onehot` (1 bit), captured with the request.
  - If captured as 1, each group bit is 1 iff i == cnt. The result is a single set bit at position WIDTH-1-cnt, or all zeros when cnt=WIDTH or saturated.
  - Latency is unchanged.
- When undefined: no extra port; only mask mode exists.

Decomposition:
- Package lz_mask_decoder_pkg contains:
  - state enum (IDLE, BUILD, DONE);
  - localparams NG and group-index width $clog2(NG);
  - a function computing CW from WIDTH.
- Sub-module lz_mask_group_slice: purely combinational.
  - Inputs: g, cnt, and onehot when enabled. Output: GROUP bits.
  - Instantiated once in the top and reused across cycles.
- The top holds the FSM, capture registers, shift/word register and handshake.

Test Plan:
- in_count=0, out_ready=1 → out_valid in cycle T+5, out_word=32'hFFFFFFFF, out_sat=0; in_ready back to 1 one cycle after the handshake.
- in_count=5 → out_word=32'h07FFFFFF. in_count=32 → 32'h00000000, out_sat=0.
- in_count=40 → out_word=0, out_sat=1. in_count=63 → same result.
- in_count=17, out_ready held low 6 cycles after out_valid → out_word=32'h00007FFF stable throughout; in_ready=0 until one cycle after the handshake.
- rst_n pulsed low during the 2nd BUILD cycle of in_count=9 → out_valid never rises; all outputs 0. A fresh in_count=1 then yields 32'h7FFFFFFF.
- With LZ_MASK_DECODER_ONEHOT_EN and in_onehot=1: in_count=5 → 32'h04000000; 0 → 32'h80000000; 32 → 0. Sweep 0..32 in mask mode → encoder(out_word)==in_count for every value.
